// File: rtl/cga_pixel_serializer_pkg.sv
// Shared constants and cell-mode helpers for the CGA pixel serializer.
package cga_pixel_serializer_pkg;

    localparam int CELL_TEXT80 = 8;
    localparam int CELL_WIDE   = 16;
    localparam int ROM_AW      = 11;

    typedef enum logic [1:0] {
        CM_TEXT80 = 2'd0,
        CM_TEXT40 = 2'd1,
        CM_GR320  = 2'd2,
        CM_GR640  = 2'd3
    } cell_mode_t;

    // Decode the mode inputs into the way one cell is shifted out.
    function automatic cell_mode_t cell_mode_sel(input logic grph, input logic hres,
                                                 input logic m640);
        if (!grph) return hres ? CM_TEXT80 : CM_TEXT40;
        return m640 ? CM_GR640 : CM_GR320;
    endfunction

    // Index of the last dot of a cell in the given mode.
    function automatic logic [3:0] last_dot(input cell_mode_t m);
        return (m == CM_TEXT80) ? 4'(CELL_TEXT80 - 1) : 4'(CELL_WIDE - 1);
    endfunction

endpackage

// File: rtl/cga_sync_delay.sv
// One pix_ce-gated register stage for CRTC sideband bits, so they line up
// with dot outputs that are themselves registered on pix_ce.
module cga_sync_delay #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_ce,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Sideband advances one dot per pix_ce and clears on reset.
    always_ff @(posedge clk) begin
        if (reset)       q <= '0;
        else if (pix_ce) q <= d;
    end

endmodule

// File: rtl/cga_pixel_serializer.sv
// Turns fetched VRAM words into a dot-rate stream: hold register, font
// capture pipe, cell counter and shifter, plus the delayed CRTC sideband.
module cga_pixel_serializer #(
    parameter int ROM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        line_start,
    input  logic        hres_mode,
    input  logic        grph_mode,
    input  logic        mode_640,
    input  logic        word_valid,
    input  logic [15:0] word_data,
    input  logic [2:0]  row_addr,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        cursor_in,
    output logic [7:0]  att_byte,
    output logic        pix_in,
    output logic        c0,
    output logic        c1,
    output logic        pix_640,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        cursor_out,
    output logic        underrun,
    output logic        overrun
);
    import cga_pixel_serializer_pkg::*;

    logic              hold_full, font_ok, hold_text;
    logic [15:0]       hold_word;
    logic [7:0]        font_byte;
    logic              rom_vld_p0, rom_vld_p1;
    logic [ROM_AW-1:0] rom_addr_q;
    logic [3:0]        dot_cnt, dot_idx, dot_nxt;
    cell_mode_t        cell_mode, mode_now;
    logic [15:0]       shifter, sh_cur, sh_next, load_val;
    logic              boundary, ready, load, font_take, issue;
    logic [3:0]        sb_q;

    assign issue     = word_valid & ~grph_mode;
    assign font_take = (ROM_LATENCY == 2) ? rom_vld_p1 : rom_vld_p0;
    assign ready     = hold_full & (~hold_text | font_ok);
    assign boundary  = pix_ce & (line_start | (dot_cnt == 4'd0));
    assign load      = boundary & ready;
    assign mode_now  = boundary ? cell_mode_sel(grph_mode, hres_mode, mode_640) : cell_mode;
    assign dot_idx   = boundary ? 4'd0 : dot_cnt;
    assign dot_nxt   = (dot_idx == last_dot(mode_now)) ? 4'd0 : 4'(dot_idx + 4'd1);
    assign load_val  = hold_text ? {font_byte, 8'h00} : hold_word;
    assign sh_cur    = boundary ? (ready ? load_val : 16'h0000) : shifter;
    assign rom_addr  = (issue & ~reset) ? {word_data[7:0], row_addr} : rom_addr_q;

    // Shift amount per dot depends on the mode of the cell in flight.
    always_comb begin
        sh_next = sh_cur;
        case (mode_now)
            CM_TEXT80: sh_next = sh_cur << 1;
            CM_TEXT40: sh_next = dot_idx[0] ? (sh_cur << 1) : sh_cur;
            CM_GR320:  sh_next = dot_idx[0] ? (sh_cur << 2) : sh_cur;
            CM_GR640:  sh_next = sh_cur << 1;
            default:   sh_next = sh_cur;
        endcase
    end

    // Hold-register occupancy and font fetch tracking; a new word cancels any fetch in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full  <= 1'b0;
            font_ok    <= 1'b0;
            rom_vld_p0 <= 1'b0;
            rom_vld_p1 <= 1'b0;
        end else begin
            rom_vld_p0 <= issue;
            rom_vld_p1 <= rom_vld_p0 & ~word_valid;
            if (word_valid) begin
                hold_full <= 1'b1;
                font_ok   <= 1'b0;
            end else begin
                if (load) hold_full <= 1'b0;
                if (font_take & hold_full) font_ok <= 1'b1;
            end
        end
    end

    // Hold-register payload and captured font row; validity lives in the control flags.
    always_ff @(posedge clk) begin
        if (word_valid) begin
            hold_word <= word_data;
            hold_text <= ~grph_mode;
        end
        if (font_take & ~word_valid) font_byte <= rom_data;
    end

    // Last issued font address, held so the ROM output stays stable between words.
    always_ff @(posedge clk) begin
        if (reset)      rom_addr_q <= '0;
        else if (issue) rom_addr_q <= {word_data[7:0], row_addr};
    end

    // Cell counter and the mode latched for the cell in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            dot_cnt   <= 4'd0;
            cell_mode <= CM_TEXT80;
        end else if (pix_ce) begin
            dot_cnt   <= dot_nxt;
            cell_mode <= mode_now;
        end
    end

    // Dot shifter; the next boundary reloads it, so reset does not need to clear it.
    always_ff @(posedge clk) begin
        if (pix_ce) shifter <= sh_next;
    end

    // Registered dot outputs, attribute and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_in   <= 1'b0;
            c0       <= 1'b0;
            c1       <= 1'b0;
            pix_640  <= 1'b0;
            att_byte <= 8'h00;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (pix_ce) begin
                pix_in  <= de_in & sh_cur[15] & ((mode_now == CM_TEXT80) | (mode_now == CM_TEXT40));
                c1      <= de_in & sh_cur[15] & (mode_now == CM_GR320);
                c0      <= de_in & sh_cur[14] & (mode_now == CM_GR320);
                pix_640 <= de_in & sh_cur[15] & (mode_now == CM_GR640);
                if (boundary) begin
                    att_byte <= (ready & hold_text) ? hold_word[15:8] : 8'h00;
                    if (!ready) underrun <= 1'b1;
                end
            end
            if (word_valid & hold_full & ~load) overrun <= 1'b1;
        end
    end

    cga_sync_delay #(.DATA_W(4)) u_sync_delay (
        .clk    (clk),
        .reset  (reset),
        .pix_ce (pix_ce),
        .d      ({de_in, hsync_in, vsync_in, cursor_in}),
        .q      (sb_q)
    );

    assign {de_out, hsync_out, vsync_out, cursor_out} = sb_q;

endmodule

// File: tb/tb_cga_pixel_serializer.sv
// Bench for cga_pixel_serializer: a cell-level model checked every clock,
// plus directed cells with literal expected dot patterns.
module tb_cga_pixel_serializer;

    localparam int L = 1;

    logic        clk = 1'b0;
    logic        reset, pix_ce, line_start, hres_mode, grph_mode, mode_640;
    logic        word_valid;
    logic [15:0] word_data;
    logic [2:0]  row_addr;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        de_in, hsync_in, vsync_in, cursor_in;
    logic [7:0]  att_byte;
    logic        pix_in, c0, c1, pix_640;
    logic        de_out, hsync_out, vsync_out, cursor_out, underrun, overrun;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cga_pixel_serializer #(.ROM_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .line_start(line_start),
        .hres_mode(hres_mode), .grph_mode(grph_mode), .mode_640(mode_640),
        .word_valid(word_valid), .word_data(word_data), .row_addr(row_addr),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .cursor_in(cursor_in),
        .att_byte(att_byte), .pix_in(pix_in), .c0(c0), .c1(c1), .pix_640(pix_640),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .cursor_out(cursor_out), .underrun(underrun), .overrun(overrun)
    );

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        if (a[10:3] == 8'h41) return 8'h18;
        return a[10:3] ^ {a[2:0], 5'b00000};
    endfunction

    // Font ROM with one clock of latency.
    always @(posedge clk) rom_data <= font_fn(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Dot k of a cell whose 16-bit image is img; result {pix_in,c1,c0,pix_640}.
    function automatic logic [3:0] dot_of(input int kind, input logic [15:0] img, input int k);
        logic [1:0] pr;
        case (kind)
            0: return {img[15-k], 3'b000};
            1: return {img[15-k/2], 3'b000};
            2: begin
                pr = 2'((img >> (14 - 2*(k/2))) & 16'h0003);
                return {1'b0, pr, 1'b0};
            end
            default: return {3'b000, img[15-k]};
        endcase
    endfunction

    // ---------------- cell-level model ----------------
    logic        m_full, m_text, m_rdy, m_took, m_bnd;
    logic [15:0] m_word, m_img;
    logic [2:0]  m_row;
    int          m_age, m_cnt, m_len, m_kind, m_idx;
    logic [3:0]  m_pat [16];
    logic [3:0]  e_dots;
    logic [7:0]  e_att;
    logic        e_de, e_hs, e_vs, e_cur, e_und, e_ovr;

    always @(posedge clk) begin
        if (reset) begin
            m_full = 0; m_age = 0; m_cnt = 0; m_len = 8; m_kind = 0;
            for (int k = 0; k < 16; k++) m_pat[k] = 4'h0;
            e_dots = 0; e_att = 0; e_de = 0; e_hs = 0; e_vs = 0; e_cur = 0;
            e_und = 0; e_ovr = 0;
        end else begin
            m_rdy  = m_full && (!m_text || m_age >= L);
            m_took = 0;
            if (pix_ce) begin
                m_bnd = line_start || (m_cnt == 0);
                if (m_bnd) begin
                    m_kind = !grph_mode ? (hres_mode ? 0 : 1) : (mode_640 ? 3 : 2);
                    m_len  = (m_kind == 0) ? 8 : 16;
                    m_img  = m_text ? {font_fn({m_word[7:0], m_row}), 8'h00} : m_word;
                    for (int k = 0; k < 16; k++) m_pat[k] = m_rdy ? dot_of(m_kind, m_img, k) : 4'h0;
                    e_att  = (m_rdy && m_text) ? m_word[15:8] : 8'h00;
                    if (!m_rdy) e_und = 1;
                    m_took = m_rdy;
                    m_idx  = 0;
                end else begin
                    m_idx = m_cnt;
                end
                e_dots = de_in ? m_pat[m_idx] : 4'h0;
                e_de = de_in; e_hs = hsync_in; e_vs = vsync_in; e_cur = cursor_in;
                m_cnt = (m_idx + 1) % m_len;
            end
            if (word_valid) begin
                if (m_full && !m_took) e_ovr = 1;
                m_full = 1; m_word = word_data; m_text = !grph_mode; m_row = row_addr; m_age = 0;
            end else begin
                if (m_took) m_full = 0;
                if (m_age < 100) m_age++;
            end
        end
        #1;
        chk("m_dots", {pix_in, c1, c0, pix_640}, e_dots);
        chk("m_att", att_byte, e_att);
        chk("m_side", {de_out, hsync_out, vsync_out, cursor_out}, {e_de, e_hs, e_vs, e_cur});
        chk("m_underrun", underrun, e_und);
        chk("m_overrun", overrun, e_ovr);
    end

    // ---------------- directed stimulus ----------------
    task automatic dot(input logic de, input logic hs, input logic ls, output logic [3:0] o);
        @(negedge clk);
        pix_ce = 1; de_in = de; hsync_in = hs; vsync_in = hs; cursor_in = ls; line_start = ls;
        @(negedge clk);
        pix_ce = 0; line_start = 0;
        o = {pix_in, c1, c0, pix_640};
    endtask

    task automatic give_word(input logic [15:0] w);
        @(negedge clk);
        word_valid = 1; word_data = w;
        #1;
        if (!grph_mode) chk("rom_addr", rom_addr, {w[7:0], row_addr});
        @(negedge clk);
        word_valid = 0;
    endtask

    logic [3:0]  o;
    logic [7:0]  b80;
    logic [15:0] b40, p16;
    logic [31:0] cc;
    logic [3:0]  acc;
    logic        pin;

    initial begin
        reset = 1; pix_ce = 0; line_start = 0; hres_mode = 1; grph_mode = 0; mode_640 = 0;
        word_valid = 0; word_data = 0; row_addr = 3'd3;
        de_in = 0; hsync_in = 0; vsync_in = 0; cursor_in = 0;
        repeat (3) @(negedge clk);
        chk("reset_dots", {pix_in, c1, c0, pix_640}, 4'h0);
        chk("reset_flags", {underrun, overrun, de_out}, 3'b000);
        reset = 0;

        // 80-column text cell; switch to 40-column for the next cell mid-way
        give_word(16'h1F41);
        for (int i = 0; i < 8; i++) begin
            dot(1, 0, i == 0, o);
            b80 = {b80[6:0], o[3]};
            if (i == 3) begin hres_mode = 0; give_word(16'h1F41); end
        end
        chk("text80_dots", b80, 8'h18);
        chk("text80_att", att_byte, 8'h1F);
        chk("text80_no_underrun", underrun, 1'b0);

        // 40-column text cell; queue a 320 graphics word mid-way
        for (int i = 0; i < 16; i++) begin
            dot(1, 0, 0, o);
            b40 = {b40[14:0], o[3]};
            if (i == 5) begin grph_mode = 1; give_word(16'hE41B); end
        end
        chk("text40_dots", b40, 16'h03C0);

        // 320 graphics cell; queue a 640 word mid-way
        pin = 0;
        for (int i = 0; i < 16; i++) begin
            dot(1, 0, 0, o);
            cc = {cc[29:0], o[2:1]};
            pin = pin | o[3];
            if (i == 5) begin mode_640 = 1; give_word(16'h8001); end
        end
        chk("gr320_pairs", cc, 32'hFA50_05AF);
        chk("gr320_pix_in_low", pin, 1'b0);
        chk("gr320_att", att_byte, 8'h00);

        // 640 graphics cell, nothing queued after it
        for (int i = 0; i < 16; i++) begin
            dot(1, 0, 0, o);
            p16 = {p16[14:0], o[0]};
        end
        chk("gr640_dots", p16, 16'h8001);
        chk("gr640_no_underrun", underrun, 1'b0);

        // underrun cell
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            dot(1, 0, 0, o);
            acc = acc | o;
        end
        chk("underrun_dots", acc, 4'h0);
        chk("underrun_flag", underrun, 1'b1);

        // overrun: two words with no boundary between
        chk("overrun_before", overrun, 1'b0);
        give_word(16'h1234);
        give_word(16'h5678);
        chk("overrun_flag", overrun, 1'b1);

        // sideband delay of exactly one pix_ce
        dot(1, 0, 0, o);
        chk("hsync_pre", hsync_out, 1'b0);
        dot(1, 1, 0, o);
        chk("hsync_on", hsync_out, 1'b1);
        dot(1, 0, 0, o);
        chk("hsync_off", hsync_out, 1'b0);

        // display enable low blanks dots
        dot(0, 0, 0, o);
        chk("de_blank_dots", o, 4'h0);
        chk("de_blank_de", de_out, 1'b0);
        dot(0, 0, 0, o);

        // reset in the middle of a text cell
        grph_mode = 0; mode_640 = 0; hres_mode = 1;
        give_word(16'h1F41);
        for (int i = 0; i < 5; i++) dot(1, 0, i == 0, o);
        chk("pre_reset_dot4", pix_in, 1'b1);
        @(negedge clk);
        reset = 1; pix_ce = 1; de_in = 1;
        @(negedge clk);
        chk("reset_mid_dots", {pix_in, c1, c0, pix_640}, 4'h0);
        chk("reset_mid_att", att_byte, 8'h00);
        chk("reset_mid_flags", {underrun, overrun, de_out, hsync_out}, 4'h0);
        chk("reset_mid_rom_addr", rom_addr, 11'h000);
        reset = 0; pix_ce = 0;

        // first cell after reset must not reuse the old word
        dot(1, 0, 0, o);
        chk("post_reset_empty", o, 4'h0);
        chk("post_reset_underrun", underrun, 1'b1);
        give_word(16'h1F41);
        for (int i = 0; i < 8; i++) begin
            dot(1, 0, i == 0, o);
            b80 = {b80[6:0], o[3]};
        end
        chk("post_reset_text80", b80, 8'h18);
        chk("post_reset_att", att_byte, 8'h1F);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
